// File: rtl/instr_imm_encoder.sv
// rtl/instr_imm_encoder.sv - packs a signed immediate into an RV32 I/S/B instruction template behind a 2-entry FIFO
module instr_imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  imm_src,
  input  logic [31:0] imm,
  input  logic [31:0] base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err,
  output logic [7:0]  err_count
);

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;

  logic [31:0] enc_instr;
  logic        enc_err;
  logic        upper_i_same;
  logic        upper_b_same;

  logic [31:0] mem_instr [2];
  logic        mem_err   [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        push;
  logic        pop;

  // Sign-extension checks: the immediate fits the field only if every bit above its top bit matches it.
  assign upper_i_same = (&imm[31:11]) | ~(|imm[31:11]);
  assign upper_b_same = (&imm[31:12]) | ~(|imm[31:12]);

  // Combinational field packing; on a range error the truncated bits are still packed.
  always_comb begin
    enc_instr = base;
    enc_err   = 1'b1;
    case (imm_src)
      SRC_I: begin
        enc_instr = {imm[11:0], base[19:0]};
        enc_err   = ~upper_i_same;
      end
      SRC_S: begin
        enc_instr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        enc_err   = ~upper_i_same;
      end
      SRC_B: begin
        enc_instr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        enc_err   = ~upper_b_same | imm[0];
      end
      default: begin
        enc_instr = base;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Ready depends only on occupancy, so a full FIFO stalls even while it is being popped.
  assign in_ready  = ~count[1];
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign instr     = out_valid ? mem_instr[rd_ptr] : 32'd0;
  assign err       = out_valid ? mem_err[rd_ptr] : 1'b0;

  // Storage write; contents need no reset because outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= enc_instr;
      mem_err[wr_ptr]   <= enc_err;
    end
  end

  // Pointers, occupancy and the saturating error counter; reset discards in-flight entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      err_count <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
      if (push && enc_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_imm_encoder.sv
// tb/tb_instr_imm_encoder.sv - self-checking bench for instr_imm_encoder against a queue-based reference model
module tb_instr_imm_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  imm_src;
  logic [31:0] imm;
  logic [31:0] base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [32:0] m_q[$];
  int          m_errcnt;

  instr_imm_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_src   (imm_src),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .err       (err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference encoding from the instruction-format rules using value ranges and shifts.
  function automatic logic [32:0] model_enc(logic [1:0] src, logic [31:0] v, logic [31:0] b);
    longint s;
    logic [31:0] o;
    logic        e;
    s = longint'($signed(v));
    case (src)
      2'd0: begin
        o = (b & 32'h000FFFFF) | ((v & 32'hFFF) << 20);
        e = !(s >= -2048 && s <= 2047);
      end
      2'd1: begin
        o = (b & 32'h01FFF07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
        e = !(s >= -2048 && s <= 2047);
      end
      2'd2: begin
        o = (b & 32'h01FFF07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
          | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
        e = !(s >= -4096 && s <= 4095) || ((v & 32'h1) != 0);
      end
      default: begin
        o = b;
        e = 1'b1;
      end
    endcase
    return {e, o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_q.size() > 0});
      chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_q.size() < 2});
      chk("cyc_err_count", {24'd0, err_count}, m_errcnt);
      chk("cyc_instr", instr, (m_q.size() > 0) ? m_q[0][31:0] : 32'd0);
      chk("cyc_err", {31'd0, err}, (m_q.size() > 0) ? {31'd0, m_q[0][32]} : 32'd0);
    end
  end

  // One clock: decide handshakes from the model, advance the model at the edge, return at negedge.
  task automatic tick();
    bit          do_push;
    bit          do_pop;
    logic [32:0] e;
    do_push = !reset && in_valid && (m_q.size() < 2);
    do_pop  = !reset && out_ready && (m_q.size() > 0);
    e = model_enc(imm_src, imm, base);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_errcnt = 0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(e);
        if (e[32] && m_errcnt < 255) m_errcnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic req(input logic [1:0] s, input logic [31:0] v, input logic [31:0] b);
    in_valid = 1'b1;
    imm_src  = s;
    imm      = v;
    base     = b;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    imm_src = 2'd0; imm = 32'd0; base = 32'd0;
    m_errcnt = 0;
    tick();
    tick();
    chk_en = 1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);

    // First cycle after reset: I-type accepted immediately.
    reset = 1'b0;
    req(2'b00, 32'hFFFFF800, 32'h00000013);
    tick();
    in_valid = 1'b0;
    chk("i_valid", {31'd0, out_valid}, 32'd1);
    chk("i_instr", instr, 32'h80000013);
    chk("i_err", {31'd0, err}, 32'd0);

    // Push S-type while popping the I-type: new entry takes the head.
    out_ready = 1'b1;
    req(2'b01, 32'h00000010, 32'h00002023);
    tick();
    chk("s_instr", instr, 32'h00002823);
    chk("s_err", {31'd0, err}, 32'd0);

    req(2'b10, 32'hFFFFFFFC, 32'h00000063);
    tick();
    chk("b_instr", instr, 32'hFE000EE3);
    chk("b_err", {31'd0, err}, 32'd0);

    req(2'b10, 32'h00000003, 32'h00000063);
    tick();
    chk("b_odd_instr", instr, 32'h00000163);
    chk("b_odd_err", {31'd0, err}, 32'd1);
    chk("b_odd_cnt", {24'd0, err_count}, 32'd1);

    req(2'b00, 32'h00000800, 32'h00000013);
    tick();
    chk("i_range_instr", instr, 32'h80000013);
    chk("i_range_err", {31'd0, err}, 32'd1);

    req(2'b11, 32'h00000000, 32'h12345678);
    tick();
    chk("rsv_instr", instr, 32'h12345678);
    chk("rsv_err", {31'd0, err}, 32'd1);
    chk("rsv_cnt", {24'd0, err_count}, 32'd3);

    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_instr", instr, 32'd0);

    // Backpressure: three back-to-back requests with the consumer stalled.
    out_ready = 1'b0;
    req(2'b00, 32'd1, 32'd0);
    tick();
    req(2'b00, 32'd2, 32'd0);
    tick();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    req(2'b00, 32'd3, 32'd0);
    tick();
    chk("bp_hold_instr", instr, 32'h00100000);
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_second_head", instr, 32'h00200000);
    tick();
    chk("bp_third_head", instr, 32'h00300000);
    in_valid = 1'b0;
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Fill with two errored entries, then reset mid-operation with traffic pending.
    out_ready = 1'b0;
    req(2'b11, 32'd0, 32'hAAAA5555);
    tick();
    req(2'b10, 32'd1, 32'h00000063);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_cnt", {24'd0, err_count}, 32'd5);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    req(2'b11, 32'd0, 32'h0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_cnt", {24'd0, err_count}, 32'd0);
    chk("post_rst_ready", {31'd0, in_ready}, 32'd1);
    req(2'b00, 32'hFFFFFFFF, 32'h00000013);
    tick();
    chk("post_rst_first", instr, 32'hFFF00013);

    // Error counter saturation with continuous push and pop.
    for (int i = 0; i < 260; i++) begin
      req(2'b11, 32'd0, 32'(i));
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("sat_cnt", {24'd0, err_count}, 32'd255);

    // Mixed stress against the model.
    for (int i = 0; i < 300; i++) begin
      req(2'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0) ? $urandom : 32'($signed($urandom_range(0, 8191)) - 4096),
          $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
